// File: rtl/me_pkg.sv
// Shared types and constants for the motion-search sequencer.
// Holds the FSM state encoding and the SAD start value helper.
package me_pkg;

  localparam int unsigned ACC_W = 18;
  localparam int unsigned MV_W  = 5;
  localparam int unsigned RANGE = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    EVAL,
    DONE
  } state_t;

  // Largest positive value of a w-bit signed SAD: the comparator compares signed.
  function automatic logic [63:0] sad_init(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/mv_raster_counter.sv
// Raster-order candidate iterator over the square window [-RANGE, +RANGE]^2.
// Holds at (+RANGE, +RANGE) once there so the final candidate stays visible.
module mv_raster_counter #(
  parameter int unsigned RANGE = 7,
  parameter int unsigned MV_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            step,
  output logic [MV_W-1:0] dx,
  output logic [MV_W-1:0] dy,
  output logic            last
);

  localparam logic [MV_W-1:0] MV_MAX = MV_W'(RANGE);
  localparam logic [MV_W-1:0] MV_MIN = ~MV_MAX + MV_W'(1);

  logic dx_end;

  assign dx_end = (dx == MV_MAX);
  assign last   = dx_end && (dy == MV_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx <= MV_MIN;
      dy <= MV_MIN;
    end else if (clear) begin
      dx <= MV_MIN;
      dy <= MV_MIN;
    end else if (step && !last) begin
      if (dx_end) begin
        dx <= MV_MIN;
        dy <= dy + MV_W'(1);
      end else begin
        dx <= dx + MV_W'(1);
      end
    end
  end

endmodule

// File: rtl/me_search_ctrl.sv
// Motion-search sequencer: walks every candidate vector through one block
// comparator, using the best SAD so far as the abort threshold.
module me_search_ctrl #(
  parameter int unsigned RANGE = me_pkg::RANGE,
  parameter int unsigned ACC_W = me_pkg::ACC_W,
  parameter int unsigned MV_W  = me_pkg::MV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             cmp_en,
  input  logic             cmp_rdy,
  input  logic             cmp_valid,
  input  logic [ACC_W-1:0] cmp_accum,
  output logic [ACC_W-1:0] cmp_oldaccum,
  output logic [MV_W-1:0]  cand_dx,
  output logic [MV_W-1:0]  cand_dy,
  output logic [MV_W-1:0]  best_dx,
  output logic [MV_W-1:0]  best_dy,
  output logic [ACC_W-1:0] best_sad,
  output logic             res_bank,
  output logic             best_bank
);

  import me_pkg::*;

  localparam logic [ACC_W-1:0] SAD_INIT = ACC_W'(sad_init(ACC_W));

  state_t           state;
  logic             smp_valid;
  logic [ACC_W-1:0] smp_accum;
  logic             cnt_clear;
  logic             cnt_step;
  logic             cnt_last;
  logic             accept;

  // Counter moves only on an accepted start (IDLE) or after a verdict (EVAL).
  assign cnt_clear    = (state == IDLE) && start;
  assign cnt_step     = (state == EVAL) && !cnt_last;
  assign accept       = smp_valid && (smp_accum < best_sad);
  assign cmp_oldaccum = best_sad;

  mv_raster_counter #(
    .RANGE (RANGE),
    .MV_W  (MV_W)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .step  (cnt_step),
    .dx    (cand_dx),
    .dy    (cand_dy),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmp_en    <= 1'b0;
      best_dx   <= '0;
      best_dy   <= '0;
      best_sad  <= SAD_INIT;
      res_bank  <= 1'b0;
      best_bank <= 1'b1;
      smp_valid <= 1'b0;
      smp_accum <= '0;
    end else begin
      done   <= 1'b0;
      cmp_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            best_sad <= SAD_INIT;
            best_dx  <= '0;
            best_dy  <= '0;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmp_rdy) begin
            cmp_en <= 1'b1;
            state  <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!cmp_rdy) begin
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (cmp_rdy) begin
            smp_valid <= cmp_valid;
            smp_accum <= cmp_accum;
            state     <= EVAL;
          end
        end
        EVAL: begin
          // Strict improvement only; the swap protects the winning residual.
          if (accept) begin
            best_dx   <= cand_dx;
            best_dy   <= cand_dy;
            best_sad  <= smp_accum;
            best_bank <= res_bank;
            res_bank  <= ~res_bank;
          end
          if (cnt_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= ISSUE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/me_search_ctrl.md
# me_search_ctrl

Motion-search sequencer for the MPEG2 encoder. It steps the block comparator through every candidate motion vector in a square window and hands it the best SAD so far as the abort threshold. It keeps the winning vector and SAD, and ping-pongs the residual write bank so the best residual is never overwritten. It sits between the encoder macroblock scheduler (start/done) and one block comparator instance.

## Interface
- RANGE, 7, search radius; candidates dx, dy ∈ [-RANGE, +RANGE], (2·RANGE+1)² total
- ACC_W, 18, SAD / accumulator width (matches comparator accum)
- MV_W, 5, signed two's-complement vector component width; must hold ±RANGE
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  one-cycle request to search the current macroblock; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse; best_* final and stable until next accepted start
- cmp_en  out  1  one-cycle enable pulse to comparator
- cmp_rdy  in  1  comparator idle/finished
- cmp_valid  in  1  comparator finished without abort (SAD ≤ threshold)
- cmp_accum  in  ACC_W  comparator final SAD
- cmp_oldaccum  out  ACC_W  abort threshold = best_sad
- cand_dx, cand_dy  out  MV_W  current candidate offset, stable from ISSUE through EVAL
- best_dx, best_dy  out  MV_W  winning vector
- best_sad  out  ACC_W  winning SAD
- res_bank  out  1  residual buffer bank the comparator writes this candidate
- best_bank  out  1  bank holding the best residual

## Operation
- Reset values: state IDLE; busy=0, done=0, cmp_en=0; cand_dx=cand_dy=-RANGE; best_dx=best_dy=0; best_sad=SAD_INIT=2^(ACC_W-1)-1 (max positive signed, because the comparator compares signed); res_bank=0, best_bank=1.
- IDLE: on start, load SAD_INIT, cand=(-RANGE,-RANGE), best vector (0,0), and go to ISSUE.
- ISSUE: assert cmp_en for exactly one cycle, only when cmp_rdy=1; otherwise hold with cmp_en=0. Then go to WAIT_LO.
- WAIT_LO: wait for cmp_rdy=0, which acknowledges the comparator started. Then go to WAIT_HI.
- WAIT_HI: wait for cmp_rdy=1. In that cycle register cmp_valid and cmp_accum, then go to EVAL.
- EVAL: accept only if the sampled valid=1 and accum < best_sad (strict).
  - On accept: best_{dx,dy,sad} ← cand/accum; best_bank ← res_bank; res_bank ← ~res_bank.
  - Ties and aborts keep the earlier winner. Banks are untouched on reject.
- Advance in raster order: dx++; when dx=+RANGE, dx ← -RANGE and dy++. When the last candidate (+RANGE,+RANGE) has been evaluated, go to DONE; otherwise go to ISSUE.
- DONE: done=1 for one cycle, then IDLE; busy drops in the same cycle done rises.
- If no candidate is ever accepted, finish with best_sad=SAD_INIT and best=(0,0).

## Timing
- Controller overhead per candidate: ISSUE 1 + WAIT_LO ≥1 + EVAL 1 cycles, plus comparator run time.
- cmp_oldaccum follows best_sad combinationally from the register; it is stable during each comparator run.
- An accepted start is visible as busy=1 the next cycle, with the first cmp_en in the cycle after that (given cmp_rdy=1).
- A start asserted in the same cycle as done is ignored.
- Reset asserted mid-search aborts immediately to reset values. The comparator is reset by the same system reset.
- cand_*, res_bank, and cmp_oldaccum change only in EVAL or IDLE.

## Structure
- Shared package me_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_LO, WAIT_HI, EVAL, DONE}
  - ACC_W, MV_W, and the SAD_INIT constant function
- One sub-module, mv_raster_counter (inputs RANGE, MV_W, clear, step; outputs dx, dy, last). It owns the candidate iteration.

## Test plan
- Basic search, RANGE=1, model SAD = 10 + |dx-1| + |dy| → 9 issues; done with best=(1,0), best_sad=10.
- Ties: all candidates SAD=5 → best=(-1,-1) (first in raster order), exactly one bank swap.
- All aborts (cmp_valid=0 every run) → best_sad=0x1FFFF, best=(0,0), res_bank=0, best_bank=1 at done.
- Slow handshake: hold cmp_rdy=0 for 3 cycles before ISSUE and delay its low ack 4 cycles → exactly one cmp_en per candidate, no double issue.
- Reset pulsed during the 5th candidate's WAIT_HI → all outputs return to reset values asynchronously. A following start searches from (-1,-1) again.
- Start asserted while busy and in the done cycle → ignored; a second start after done runs a full fresh search.
